// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner. It drives one row at a time, synchronizes the columns,
// debounces press and release over scan ticks, and emits one strobe per accepted key stroke.
module keypad_scanner #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [31:0] number,
  output logic [1:0]  pressed,
  output logic        key_held,
  output logic        key_strobe,
  output logic        is_digit
);

  localparam int                CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(SCAN_DIV - 1);
  localparam int                DEB_W     = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DEB_W-1:0]  DEB_DONE  = DEB_W'(DEBOUNCE_SCANS);
  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t           state;
  logic [3:0]       col_meta;
  logic [3:0]       col_sync;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic [1:0]       row_idx;
  logic [1:0]       next_row;
  logic [1:0]       cand_col;
  logic [1:0]       first_col;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] deb_next;
  logic             any_low;
  logic             cand_low;
  logic [3:0]       accept_code;

  // Physical layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    key_code = 4'd0;
    case ({row, col})
      4'h0: key_code = 4'd1;   4'h1: key_code = 4'd2;   4'h2: key_code = 4'd3;   4'h3: key_code = 4'd10;
      4'h4: key_code = 4'd4;   4'h5: key_code = 4'd5;   4'h6: key_code = 4'd6;   4'h7: key_code = 4'd11;
      4'h8: key_code = 4'd7;   4'h9: key_code = 4'd8;   4'hA: key_code = 4'd9;   4'hB: key_code = 4'd12;
      4'hC: key_code = 4'd14;  4'hD: key_code = 4'd0;   4'hE: key_code = 4'd15;  4'hF: key_code = 4'd13;
      default: key_code = 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    row_drive = ~(4'b0001 << idx);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TICK_LAST);

  // NOTE: every variable gets a default before the branches, so no latches are inferred.
  always_comb begin
    first_col = 2'd3;
    if      (!col_sync[0]) first_col = 2'd0;
    else if (!col_sync[1]) first_col = 2'd1;
    else if (!col_sync[2]) first_col = 2'd2;
    any_low     = (col_sync != 4'b1111);
    cand_low    = !col_sync[cand_col];
    next_row    = row_idx + 2'd1;
    deb_next    = deb_cnt + DEB_ONE;
    accept_code = key_code(row_idx, (state == SCAN) ? first_col : cand_col);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SCAN;
      row_idx    <= 2'd0;
      row_n      <= 4'b1110;
      cand_col   <= 2'd0;
      deb_cnt    <= '0;
      number     <= '0;
      key_held   <= 1'b0;
      key_strobe <= 1'b0;
      is_digit   <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (any_low) begin
              cand_col <= first_col;
              deb_cnt  <= DEB_ONE;
              if (DEB_ONE == DEB_DONE) begin
                state      <= HELD;
                key_strobe <= 1'b1;
                key_held   <= 1'b1;
                number     <= {28'd0, accept_code};
                is_digit   <= (accept_code <= 4'd9);
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              row_idx <= next_row;
              row_n   <= row_drive(next_row);
            end
          end
          DEBOUNCE: begin
            if (cand_low) begin
              deb_cnt <= deb_next;
              if (deb_next == DEB_DONE) begin
                state      <= HELD;
                key_strobe <= 1'b1;
                key_held   <= 1'b1;
                number     <= {28'd0, accept_code};
                is_digit   <= (accept_code <= 4'd9);
              end
            end else begin
              state   <= SCAN;
              row_idx <= next_row;
              row_n   <= row_drive(next_row);
            end
          end
          HELD: begin
            if (!cand_low) begin
              deb_cnt <= DEB_ONE;
              if (DEB_ONE == DEB_DONE) begin
                state    <= SCAN;
                key_held <= 1'b0;
                row_idx  <= next_row;
                row_n    <= row_drive(next_row);
              end else begin
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (!cand_low) begin
              deb_cnt <= deb_next;
              if (deb_next == DEB_DONE) begin
                state    <= SCAN;
                key_held <= 1'b0;
                row_idx  <= next_row;
                row_n    <= row_drive(next_row);
              end
            end else begin
              // A release bounce returns to HELD silently: no second strobe.
              state <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

  assign pressed = {1'b0, key_held};

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulates the key matrix and checks presses, releases and bounces
// against a keymap and timing rules derived from the scanner's behaviour.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int LAT_MAX  = 2 + SCAN_DIV * (4 + DEB);
  localparam int REL_MAX  = 2 + SCAN_DIV * (DEB + 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [31:0] number;
  logic [1:0]  pressed;
  logic        key_held;
  logic        key_strobe;
  logic        is_digit;

  logic [15:0] keys = '0;
  int          n_vec = 0;
  int          n_err = 0;
  int          strobe_total = 0;
  int          consec = 0;
  logic        prev_strobe = 1'b0;
  string       keymap = "123A456B789C*0#D";

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .col_n(col_n), .row_n(row_n), .number(number),
    .pressed(pressed), .key_held(key_held), .key_strobe(key_strobe), .is_digit(is_digit)
  );

  always #5 clk = ~clk;

  // Passive matrix: a held key shorts its column low while its row is driven low.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_strobe === 1'b1) strobe_total <= strobe_total + 1;
    if (key_strobe === 1'b1 && prev_strobe === 1'b1) consec <= consec + 1;
    prev_strobe <= key_strobe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int key_code(int r, int c);
    byte ch;
    ch = keymap[r*4+c];
    if (ch >= "0" && ch <= "9") return int'(ch) - int'("0");
    if (ch >= "A" && ch <= "D") return 10 + int'(ch) - int'("A");
    if (ch == "*") return 14;
    return 15;
  endfunction

  function automatic logic [15:0] key_bit(int r, int c);
    logic [15:0] m;
    m = '0;
    m[r*4+c] = 1'b1;
    return m;
  endfunction

  task automatic wait_strobe(output bit found, output int lat);
    found = 1'b0;
    lat   = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (key_strobe === 1'b1) begin
        found = 1'b1;
        lat   = i;
        break;
      end
    end
  endtask

  task automatic press_and_check(string name, logic [15:0] mask, int exp_code, int hold_ticks);
    bit found;
    int lat;
    int s0;
    s0   = strobe_total;
    keys = mask;
    wait_strobe(found, lat);
    n_vec++; if (found !== 1'b1) begin n_err++; $display("FAIL %s strobe: got none expected one within 80 clks", name); end
    n_vec++; if (lat > LAT_MAX) begin n_err++; $display("FAIL %s latency: got %0d expected <= %0d", name, lat, LAT_MAX); end
    n_vec++; if (number !== 32'(exp_code)) begin n_err++; $display("FAIL %s number: got %0d expected %0d", name, number, exp_code); end
    n_vec++; if (is_digit !== (exp_code <= 9)) begin n_err++; $display("FAIL %s is_digit: got %b expected %b", name, is_digit, exp_code <= 9); end
    n_vec++; if (pressed !== 2'b01) begin n_err++; $display("FAIL %s pressed: got %b expected 01", name, pressed); end
    repeat (hold_ticks * SCAN_DIV) @(negedge clk);
    n_vec++; if (key_held !== 1'b1) begin n_err++; $display("FAIL %s held: got %b expected 1", name, key_held); end
    n_vec++; if (strobe_total - s0 !== 1) begin n_err++; $display("FAIL %s strobe count: got %0d expected 1", name, strobe_total - s0); end
  endtask

  task automatic release_and_check(string name, int exp_code);
    int lat;
    keys = '0;
    lat  = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (key_held === 1'b0) begin lat = i; break; end
    end
    n_vec++; if (lat == 0 || lat > REL_MAX) begin n_err++; $display("FAIL %s release: got %0d clks expected 1..%0d", name, lat, REL_MAX); end
    n_vec++; if (number !== 32'(exp_code) || pressed !== 2'b00) begin n_err++; $display("FAIL %s after release: got number %0d pressed %b expected %0d 00", name, number, pressed, exp_code); end
    repeat (2 * SCAN_DIV) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    keys  = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (row_n !== 4'b1110) begin n_err++; $display("FAIL reset row_n: got %b expected 1110", row_n); end
    n_vec++; if (number !== 32'd0 || is_digit !== 1'b0) begin n_err++; $display("FAIL reset number: got %0d/%b expected 0/0", number, is_digit); end
    n_vec++; if (key_held !== 1'b0 || key_strobe !== 1'b0 || pressed !== 2'b00) begin n_err++; $display("FAIL reset flags: got %b%b%b expected 000", key_held, key_strobe, pressed); end
    rst_n = 1'b1;
    repeat (8 * SCAN_DIV) @(negedge clk);
    n_vec++; if (strobe_total !== 0) begin n_err++; $display("FAIL idle strobes: got %0d expected 0", strobe_total); end
  endtask

  task automatic test_reset_mid_held();
    int s0;
    press_and_check("pre_reset_2", key_bit(0, 1), 2, 1);
    rst_n = 1'b0;
    s0 = strobe_total;
    @(negedge clk);
    n_vec++; if (key_held !== 1'b0 || number !== 32'd0 || is_digit !== 1'b0) begin n_err++; $display("FAIL midheld reset: got held %b number %0d expected 0 0", key_held, number); end
    n_vec++; if (row_n !== 4'b1110 || key_strobe !== 1'b0) begin n_err++; $display("FAIL midheld row/strobe: got %b %b expected 1110 0", row_n, key_strobe); end
    keys  = '0;
    rst_n = 1'b1;
    repeat (3 * SCAN_DIV) @(negedge clk);
    n_vec++; if (strobe_total !== s0) begin n_err++; $display("FAIL midheld strobes: got %0d expected %0d", strobe_total, s0); end
  endtask

  task automatic test_press_release_5();
    bit found;
    int lat;
    int s0;
    s0   = strobe_total;
    keys = key_bit(1, 1);
    wait_strobe(found, lat);
    n_vec++; if (found !== 1'b1 || number !== 32'd5 || is_digit !== 1'b1 || pressed !== 2'b01) begin n_err++; $display("FAIL key5 accept: got found %b number %0d digit %b pressed %b expected 1 5 1 01", found, number, is_digit, pressed); end
    // Released right after the accepting tick: the third high tick lands 12 clks later.
    keys = '0;
    repeat (3 * SCAN_DIV - 1) @(negedge clk);
    n_vec++; if (key_held !== 1'b1) begin n_err++; $display("FAIL key5 early release: got %b expected 1", key_held); end
    @(negedge clk);
    n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL key5 release: got %b expected 0", key_held); end
    n_vec++; if (strobe_total - s0 !== 1 || number !== 32'd5) begin n_err++; $display("FAIL key5 strobes/number: got %0d %0d expected 1 5", strobe_total - s0, number); end
    repeat (2 * SCAN_DIV) @(negedge clk);
  endtask

  task automatic test_bounce_7();
    int s0;
    bit held_seen;
    s0 = strobe_total;
    held_seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      keys = (t % 2 == 0) ? key_bit(2, 0) : 16'd0;
      repeat (SCAN_DIV) begin
        @(negedge clk);
        if (key_held === 1'b1) held_seen = 1'b1;
      end
    end
    keys = '0;
    repeat (2 * SCAN_DIV) @(negedge clk);
    n_vec++; if (strobe_total - s0 !== 0) begin n_err++; $display("FAIL bounce7 strobes: got %0d expected 0", strobe_total - s0); end
    n_vec++; if (held_seen !== 1'b0) begin n_err++; $display("FAIL bounce7 held: got %b expected 0", held_seen); end
  endtask

  task automatic test_function_keys();
    press_and_check("key_D", key_bit(3, 3), 13, 2);
    release_and_check("key_D", 13);
    press_and_check("key_hash", key_bit(3, 2), 15, 2);
    release_and_check("key_hash", 15);
  endtask

  task automatic test_two_keys();
    press_and_check("keys_1_3", key_bit(0, 0) | key_bit(0, 2), 1, 3);
    release_and_check("keys_1_3", 1);
  endtask

  task automatic test_release_bounce_0();
    bit found;
    int lat;
    int s0;
    bit dropped;
    s0 = strobe_total;
    dropped = 1'b0;
    keys = key_bit(3, 1);
    wait_strobe(found, lat);
    n_vec++; if (found !== 1'b1 || number !== 32'd0 || is_digit !== 1'b1) begin n_err++; $display("FAIL key0 accept: got found %b number %0d digit %b expected 1 0 1", found, number, is_digit); end
    // High for exactly two ticks, then low again before the third.
    keys = '0;
    repeat (2 * SCAN_DIV) @(negedge clk);
    keys = key_bit(3, 1);
    repeat (10 * SCAN_DIV) begin
      @(negedge clk);
      if (key_held !== 1'b1) dropped = 1'b1;
    end
    n_vec++; if (dropped !== 1'b0) begin n_err++; $display("FAIL key0 bounce held: got dropped %b expected 0", dropped); end
    n_vec++; if (strobe_total - s0 !== 1) begin n_err++; $display("FAIL key0 bounce strobes: got %0d expected 1", strobe_total - s0); end
    release_and_check("key0_final", 0);
  endtask

  task automatic test_random();
    int r;
    int cols;
    int lowest;
    logic [15:0] mask;
    for (int n = 0; n < 10; n++) begin
      r      = int'($urandom_range(3, 0));
      cols   = int'($urandom_range(15, 1));
      mask   = '0;
      lowest = -1;
      for (int c = 3; c >= 0; c--)
        if (cols[c]) begin
          mask   = mask | key_bit(r, c);
          lowest = c;
        end
      press_and_check($sformatf("rand%0d_r%0d_c%h", n, r, cols[3:0]), mask, key_code(r, lowest), int'($urandom_range(6, 1)));
      release_and_check($sformatf("rand%0d", n), key_code(r, lowest));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_held();
    test_press_release_5();
    test_bounce_7();
    test_function_keys();
    test_two_keys();
    test_release_bounce_0();
    test_random();
    n_vec++; if (consec !== 0) begin n_err++; $display("FAIL back_to_back strobes: got %0d expected 0", consec); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
